ram_burst_master: RTL and testbench
===================================

Name: ram_burst_master

Overview:
- Initiator for the 1Kx8 single-port synchronous RAM.
- Accepts one burst command at a time (start address, length, direction) and sequences the RAM's en/we/addr/data pins.
- Write bursts take bytes from a valid/ready write stream. Read bursts return bytes on a valid/ready read stream, with a last flag.
- Sits between a host/DMA-style client and the RAM instance.

Parameters:
- ADDR_W, 10, RAM address width (1024 locations).
- DATA_W, 8, RAM data width.
- FIFO_DEPTH, 4, read-return buffer entries. Minimum 3 for full read throughput; power of two.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  ADDR_W  burst length minus 1 (0 means 1 byte, 1023 means 1024 bytes).
- wr_valid  in  1  write byte offered.
- wr_ready  out  1  write byte accepted.
- wr_data  in  DATA_W  write byte.
- rd_valid  out  1  read byte available.
- rd_ready  in  1  consumer takes read byte.
- rd_data  out  DATA_W  read byte.
- rd_last  out  1  marks the final byte of a read burst.
- done  out  1  one-cycle pulse when a burst completes.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_data  out  DATA_W  data to RAM.
- ram_dout  in  DATA_W  RAM read data; registered inside the RAM, valid the cycle after a read issue, Z when not enabled.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, address/count registers and FIFO cleared, in-flight flag=0. cmd_ready=1, all other outputs 0.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready=1 and ram_en=0.
  - On cmd_valid: latch cur_addr=cmd_addr and remaining=cmd_len. Go to WRITE if cmd_write=1, else READ.
  - cmd_ready=0 in every other state.
- WRITE:
  - wr_ready=1.
  - ram_en=ram_we=wr_valid, ram_addr=cur_addr, ram_data=wr_data. These are combinational, so the RAM captures the byte on the same edge as the handshake.
  - On each beat: cur_addr+1 and remaining-1.
  - Beat with remaining==0: pulse done the next cycle and return to IDLE.
  - wr_valid gaps insert idle cycles with ram_en=0.
- READ:
  - issue = (fifo_count + inflight < FIFO_DEPTH). ram_en=issue, ram_we=0, ram_addr=cur_addr.
  - Each issue sets inflight for one cycle. The following edge pushes ram_dout into the FIFO, tagged last if it was the final address.
  - After issuing the byte with remaining==0: go to DRAIN.
- DRAIN:
  - No issues; ram_en=0.
  - Wait for the final in-flight byte to land and for the FIFO to empty.
  - The pop of the last-tagged entry pulses done the following cycle, then return to IDLE.
- Read stream:
  - rd_valid = FIFO non-empty; rd_data/rd_last = FIFO head.
  - Pop on rd_valid&rd_ready.
  - Head must hold stable while rd_ready=0.
  - Latency: issue edge E0, FIFO push at E1, rd_valid high after E1, i.e. 2 cycles.
  - Back-to-back output every cycle when rd_ready is held high.
- ram_dout is sampled only in the cycle after an issue; Z values at any other time are never captured.
- Address arithmetic is modulo 2^ADDR_W: 1023+1 wraps to 0 and the burst continues.
- A simultaneous FIFO push and pop leaves the count unchanged.
- wr_ready=0 outside WRITE; rd_valid only from FIFO contents.
- Reset mid-burst aborts immediately: no partial done, FIFO emptied, ram_en drops asynchronously with state.

Decomposition:
- Package ram_burst_pkg: state enum (IDLE, WRITE, READ, DRAIN), ADDR_W/DATA_W defaults, FIFO entry struct {data, last}.
- Sub-module ram_rd_fifo: sync FIFO of DATA_W+1 bits, depth FIFO_DEPTH, async active-low reset, with push/pop/count/empty.

Test Plan:
- Write addr=0x010, len=3, bytes A1 A2 A3 A4 with wr_valid held high -> ram_we on 4 consecutive cycles, ram_addr 0x010..0x013; done pulses 1 cycle after the 4th beat; cmd_ready back to 1.
- Read back addr=0x010, len=3 with rd_ready=1 -> rd_data A1 A2 A3 A4 on 4 consecutive cycles; first byte 2 cycles after the first issue; rd_last only on A4; done 1 cycle after the A4 pop.
- Wrap: write addr=0x3FE, len=3, bytes 11 22 33 44, then read the same range -> addresses 3FE, 3FF, 000, 001; data 11 22 33 44.
- Backpressure: read len=7 with rd_ready toggling 1,0,0,1,... -> no lost or duplicated bytes, issues stall once fifo_count+inflight=4, order preserved, rd_data stable while stalled.
- wr_valid gaps: write len=2 with wr_valid pattern 1,0,1,0,1 -> ram_en only on valid cycles, addresses contiguous.
- Reset mid-read (rst_n low after 2 bytes delivered, len=7) -> all outputs 0 immediately, no done pulse; a new command is accepted after release.

Source files
------------

// File: rtl/ram_burst_master_pkg.sv
// Shared types and default sizing for the 1Kx8 RAM burst initiator.
package ram_burst_pkg;

    localparam int RB_ADDR_W     = 10;
    localparam int RB_DATA_W     = 8;
    localparam int RB_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // One read-return buffer entry: the byte plus its end-of-burst tag.
    typedef struct packed {
        logic [RB_DATA_W-1:0] data;
        logic                 last;
    } rd_entry_t;

endpackage

// File: rtl/ram_burst_master_if.sv
// Client-side command/stream handshakes plus the RAM pin bundle of the burst master.
interface ram_burst_master_if
    import ram_burst_pkg::*;
#(
    parameter int ADDR_W = RB_ADDR_W,
    parameter int DATA_W = RB_DATA_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    logic              done;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] ram_dout;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data,
        input  rd_ready,
        input  ram_dout,
        output cmd_ready, wr_ready,
        output rd_valid, rd_data, rd_last,
        output done,
        output ram_en, ram_we, ram_addr, ram_data
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data,
        output rd_ready,
        output ram_dout,
        input  cmd_ready, wr_ready,
        input  rd_valid, rd_data, rd_last,
        input  done,
        input  ram_en, ram_we, ram_addr, ram_data
    );

endinterface

// File: rtl/ram_burst_master_rd_fifo.sv
// Synchronous read-return FIFO; head is forced to zero while empty.
module ram_rd_fifo
    import ram_burst_pkg::*;
#(
    parameter int WIDTH = RB_DATA_W + 1,
    parameter int DEPTH = RB_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    // NOTE: storage is not reset; only pointers and count are, which is enough to make it empty.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = o_empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for a 1Kx8 single-port synchronous RAM: write bursts from a
// valid/ready stream, read bursts returned through a small credit-limited FIFO.
module ram_burst_master
    import ram_burst_pkg::*;
#(
    parameter int ADDR_W     = RB_ADDR_W,
    parameter int DATA_W     = RB_DATA_W,
    parameter int FIFO_DEPTH = RB_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_burst_master_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [CNT_W:0]    DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_done;

    logic              w_accept;
    logic              w_final;
    logic              w_wr_beat;
    logic              w_issue;
    logic              w_pop;
    logic              w_pop_last;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_occupancy;
    logic              w_empty;
    logic [DATA_W:0]   w_head;

    assign w_accept  = (r_state == IDLE) && bus.cmd_valid;
    assign w_final   = (r_remaining == '0);
    assign w_wr_beat = (r_state == WRITE) && bus.wr_valid;

    // Credit check: bytes already in the FIFO plus the one still in the RAM pipeline.
    assign w_occupancy = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_issue     = (r_state == READ) && (w_occupancy < DEPTH_LIM);

    assign w_pop      = !w_empty && bus.rd_ready;
    assign w_pop_last = w_pop && w_head[DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.cmd_valid) w_next_state = bus.cmd_write ? WRITE : READ;
            WRITE:   if (w_wr_beat && w_final) w_next_state = IDLE;
            READ:    if (w_issue && w_final) w_next_state = DRAIN;
            DRAIN:   if (w_pop_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves a latch.
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_data  = '0;
        case (r_state)
            IDLE: bus.cmd_ready = 1'b1;
            WRITE: begin
                bus.wr_ready = 1'b1;
                bus.ram_en   = bus.wr_valid;
                bus.ram_we   = bus.wr_valid;
                bus.ram_addr = r_cur_addr;
                bus.ram_data = bus.wr_data;
            end
            READ: begin
                bus.ram_en   = w_issue;
                bus.ram_addr = r_cur_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_addr      <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cur_addr  <= bus.cmd_addr;
                r_remaining <= bus.cmd_len;
            end else if (w_wr_beat || w_issue) begin
                r_cur_addr  <= r_cur_addr + ADDR_ONE;
                r_remaining <= r_remaining - ADDR_ONE;
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_final;
            r_done          <= (w_wr_beat && w_final) || ((r_state == DRAIN) && w_pop_last);
        end
    end

    // ram_dout is only captured the cycle after an issue, so a floating bus is never stored.
    ram_rd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data ({r_inflight_last, bus.ram_dout}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_empty     (w_empty)
    );

    assign bus.rd_valid = !w_empty;
    assign bus.rd_data  = w_head[DATA_W-1:0];
    assign bus.rd_last  = w_head[DATA_W];
    assign bus.done     = r_done;

endmodule

// File: tb/tb_ram_burst_master.sv
// Scoreboard bench for ram_burst_master with a behavioural 1Kx8 registered-output RAM.
module tb_ram_burst_master;
    import ram_burst_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;

    ram_burst_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_burst_master #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read data, bus floats when the previous cycle was not a read.
    logic [DW-1:0] ram_mem [1024];
    logic [DW-1:0] ram_q;
    logic          ram_oe;

    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_data;
            else            ram_q <= ram_mem[bus.ram_addr];
        end
        ram_oe <= bus.ram_en && !bus.ram_we;
    end

    assign bus.ram_dout = ram_oe ? ram_q : 'z;

    int n_cmp;
    int n_bad;

    logic [DW-1:0]    shadow [1024];
    logic [DW-1:0]    stim [$];
    logic [AW+DW-1:0] wr_q [$];
    logic [AW-1:0]    addr_q [$];
    rd_entry_t        rd_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [AW-1:0] len,
                            input logic [31:0] vpat, input int plen);
        int idx;
        int k;
        logic [AW-1:0]    a;
        logic [AW+DW-1:0] e;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        @(negedge clk);
        check("wr_cmd_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + AW'(i);
            wr_q.push_back({a, stim[i]});
            shadow[a] = stim[i];
        end
        idx = 0;
        k   = 0;
        while (idx <= int'(len) && k < 200) begin
            bus.wr_valid = vpat[k % plen];
            bus.wr_data  = stim[idx];
            @(negedge clk);
            check("wr_ready", bus.wr_ready, 1);
            check("wr_en_we", {bus.ram_en, bus.ram_we}, {2{bus.wr_valid}});
            check("wr_early_done", bus.done, 0);
            if (bus.wr_valid) begin
                if (wr_q.size() == 0) begin
                    check("wr_extra_beat", 1, 0);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_addr", bus.ram_addr, e[AW+DW-1:DW]);
                    check("wr_data", bus.ram_data, e[DW-1:0]);
                end
            end
            tick();
            if (bus.wr_valid) idx++;
            k++;
        end
        bus.wr_valid = 1'b0;
        check("wr_beats", idx, int'(len) + 1);
        check("wr_done", bus.done, 1);
        check("wr_cmd_ready_after", bus.cmd_ready, 1);
        check("wr_ready_after", bus.wr_ready, 0);
        tick();
        check("wr_done_width", bus.done, 0);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [AW-1:0] len,
                           input logic [31:0] rpat, input int plen, input int rst_after);
        int        issued;
        int        popped;
        int        k;
        int        first_valid;
        bit        prev_stall;
        bit        hs;
        bit        en_s;
        bit        was_last;
        bit        finished;
        logic [DW:0]   prev_head;
        logic [AW-1:0] a;
        rd_entry_t     ent;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        @(negedge clk);
        check("rd_cmd_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + AW'(i);
            addr_q.push_back(a);
            rd_q.push_back('{data: shadow[a], last: (i == int'(len))});
        end
        issued = 0; popped = 0; k = 0; first_valid = -1;
        prev_stall = 1'b0; prev_head = '0; finished = 1'b0;
        while (!finished && k < 300) begin
            bus.rd_ready = rpat[k % plen];
            @(negedge clk);
            en_s = bus.ram_en;
            check("rd_issue", en_s, (issued <= int'(len)) && (issued - popped < DEPTH));
            check("rd_early_done", bus.done, 0);
            if (en_s) begin
                check("rd_we", bus.ram_we, 0);
                if (addr_q.size() == 0) check("rd_extra_issue", 1, 0);
                else                    check("rd_addr", bus.ram_addr, addr_q.pop_front());
            end
            if (bus.rd_valid && first_valid < 0) begin
                first_valid = k;
                check("rd_latency", k, 2);
            end
            if (prev_stall) check("rd_hold", {bus.rd_valid, bus.rd_last, bus.rd_data}, {1'b1, prev_head});
            hs       = bus.rd_valid && bus.rd_ready;
            was_last = 1'b0;
            if (hs) begin
                if (rd_q.size() == 0) begin
                    check("rd_extra_byte", 1, 0);
                end else begin
                    ent = rd_q.pop_front();
                    check("rd_data", bus.rd_data, ent.data);
                    check("rd_last", bus.rd_last, ent.last);
                    was_last = ent.last;
                end
            end
            prev_stall = bus.rd_valid && !bus.rd_ready;
            prev_head  = {bus.rd_last, bus.rd_data};
            tick();
            k++;
            if (en_s) issued++;
            if (hs)   popped++;
            if (rst_after > 0 && popped == rst_after) begin
                rst_n = 1'b0;
                #1;
                check("rst_cmd_ready", bus.cmd_ready, 1);
                check("rst_rd_valid", bus.rd_valid, 0);
                check("rst_ram_en", bus.ram_en, 0);
                check("rst_done", bus.done, 0);
                check("rst_rd_head", {bus.rd_last, bus.rd_data}, 0);
                repeat (3) begin
                    tick();
                    check("rst_hold_done", bus.done, 0);
                    check("rst_hold_en", bus.ram_en, 0);
                end
                rst_n        = 1'b1;
                bus.rd_ready = 1'b0;
                rd_q.delete();
                addr_q.delete();
                tick();
                check("rst_no_done_after", bus.done, 0);
                return;
            end
            if (was_last) finished = 1'b1;
        end
        bus.rd_ready = 1'b0;
        check("rd_finished", finished, 1);
        check("rd_done", bus.done, 1);
        check("rd_cmd_ready_after", bus.cmd_ready, 1);
        check("rd_fifo_empty", bus.rd_valid, 0);
        tick();
        check("rd_done_width", bus.done, 0);
        check("rd_queue_empty", rd_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;
        #1;
        check("reset_cmd_ready", bus.cmd_ready, 1);
        check("reset_wr_ready", bus.wr_ready, 0);
        check("reset_rd_valid", bus.rd_valid, 0);
        check("reset_rd_head", {bus.rd_last, bus.rd_data}, 0);
        check("reset_done", bus.done, 0);
        check("reset_ram_ctl", {bus.ram_en, bus.ram_we}, 0);
        check("reset_ram_bus", {bus.ram_addr, bus.ram_data}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        stim = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        do_write(10'h010, 10'd3, 32'hFFFF_FFFF, 1);
        do_read(10'h010, 10'd3, 32'hFFFF_FFFF, 1, 0);

        stim = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_write(10'h3FE, 10'd3, 32'hFFFF_FFFF, 1);
        do_read(10'h3FE, 10'd3, 32'hFFFF_FFFF, 1, 0);

        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
        do_write(10'h100, 10'd7, 32'hFFFF_FFFF, 1);
        do_read(10'h100, 10'd7, 32'b1001, 4, 0);

        stim = '{8'h5A, 8'hC3, 8'h0F};
        do_write(10'h080, 10'd2, 32'b10101, 5);
        do_read(10'h080, 10'd2, 32'hFFFF_FFFF, 1, 0);

        do_read(10'h100, 10'd7, 32'hFFFF_FFFF, 1, 2);
        do_read(10'h010, 10'd3, 32'hFFFF_FFFF, 1, 0);

        check("wr_queue_drained", wr_q.size(), 0);
        check("addr_queue_drained", addr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
